// File: rtl/ftdi_245fifo_pkg.sv
// Shared types and constants for the FTDI 245-FIFO arbitration FSM.
`timescale 1ns/1ps
package ftdi_245fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_OE,
      ST_RX_EN,
      ST_RX_WAIT,
      ST_RX_END,
      ST_TX_EN,
      ST_TURN
   } state_t;

   typedef enum logic {
      DIR_RX = 1'b0,
      DIR_TX = 1'b1
   } dir_t;

   // Widest supported chip (FT601, 32 bits); narrower chips slice these.
   localparam int CHIP_W_MAX = 32;
   localparam int CHIP_K_MAX = 4;

   localparam logic [CHIP_K_MAX-1:0] BE_ALL_ONE = '1;
   localparam logic [CHIP_K_MAX-1:0] BE_ZERO    = '0;
   localparam logic [CHIP_W_MAX-1:0] DATA_ZERO  = '0;

   function automatic int chip_w(input int ew);
      return 8 << ew;
   endfunction

   function automatic int chip_k(input int ew);
      return 1 << ew;
   endfunction

endpackage

// File: rtl/ftdi_245fifo_burst_cnt.sv
// Per-grant beat counter: cleared at grant start, flags the final allowed beat.
`timescale 1ns/1ps
module ftdi_245fifo_burst_cnt #(
   parameter int MAX = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic inc,
   output logic last
);

   // Sized to hold MAX; the burst ends on the beat at MAX-1 so it never wraps.
   localparam int CW = $clog2(MAX + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign last = (cnt == CW'(MAX - 1));

endmodule

// File: rtl/ftdi_245fifo_arb_fsm.sv
// FTDI 245-FIFO control FSM: fair RX/TX arbitration with burst limits,
// bus turnaround gap and clean termination on partial TX words.
`timescale 1ns/1ps
module ftdi_245fifo_arb_fsm
   import ftdi_245fifo_pkg::*;
#(
   parameter int CHIP_EW          = 0,
   parameter int RX_BURST_MAX     = 64,
   parameter int TX_BURST_MAX     = 64,
   parameter int TURNAROUND       = 1,
   parameter bit DRIVE_AT_NEGEDGE = 1'b0,
   localparam int W = chip_w(CHIP_EW),
   localparam int K = chip_k(CHIP_EW)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         tx_tvalid,
   output logic         tx_tready,
   input  logic [W-1:0] tx_tdata,
   input  logic [K-1:0] tx_tkeep,
   input  logic         rx_almost_full,
   output logic         rx_tvalid,
   output logic [W-1:0] rx_tdata,
   output logic [K-1:0] rx_tkeep,
   output logic         rx_tlast,
   input  logic         ftdi_rxf_n,
   input  logic         ftdi_txe_n,
   output logic         ftdi_oe_n,
   output logic         ftdi_rd_n,
   output logic         ftdi_wr_n,
   output logic         ftdi_master_oe,
   output logic [W-1:0] ftdi_data_out,
   output logic [K-1:0] ftdi_be_out,
   input  logic [W-1:0] ftdi_data_in,
   input  logic [K-1:0] ftdi_be_in,
   output logic         rx_active,
   output logic         tx_active
);

   localparam int TURN_W = $clog2(TURNAROUND + 1);
   localparam logic [K-1:0] KEEP_ALL  = BE_ALL_ONE[K-1:0];
   localparam logic [K-1:0] KEEP_NONE = BE_ZERO[K-1:0];
   localparam logic [W-1:0] WORD_NONE = DATA_ZERO[W-1:0];

   state_t            state, state_next;
   dir_t              last_dir, last_dir_next;
   logic [TURN_W-1:0] turn_cnt;
   logic              rx_req, tx_req, rx_beat, tx_beat;
   logic              rx_last, tx_last, turn_done;
   logic              oe_c, rd_c, wr_c, moe_c;
   logic [W-1:0]      data_c;
   logic [K-1:0]      be_c;

   assign rx_req    = ~ftdi_rxf_n & ~rx_almost_full;
   assign tx_req    = ~ftdi_txe_n & tx_tvalid;
   assign rx_beat   = (state == ST_RX_EN) & ~ftdi_rxf_n;
   assign tx_beat   = (state == ST_TX_EN) & tx_tvalid & ~ftdi_txe_n;
   assign turn_done = (state == ST_TURN) & (turn_cnt == TURN_W'(TURNAROUND - 1));

   ftdi_245fifo_burst_cnt #(.MAX(RX_BURST_MAX)) u_rx_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (state == ST_RX_OE),
      .inc  (rx_beat),
      .last (rx_last)
   );

   ftdi_245fifo_burst_cnt #(.MAX(TX_BURST_MAX)) u_tx_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (state != ST_TX_EN),
      .inc  (tx_beat),
      .last (tx_last)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         last_dir <= DIR_TX;
      end else begin
         state    <= state_next;
         last_dir <= last_dir_next;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         turn_cnt <= '0;
      end else if ((state == ST_TURN) && !turn_done) begin
         turn_cnt <= turn_cnt + TURN_W'(1);
      end else begin
         turn_cnt <= '0;
      end
   end

   always_comb begin
      state_next    = state;
      last_dir_next = last_dir;
      case (state)
         ST_IDLE: begin
            // On a tie the direction not served last time wins.
            if (rx_req && (!tx_req || last_dir == DIR_TX)) begin
               state_next    = ST_RX_OE;
               last_dir_next = DIR_RX;
            end else if (tx_req) begin
               state_next    = ST_TX_EN;
               last_dir_next = DIR_TX;
            end
         end
         ST_RX_OE:   state_next = ST_RX_EN;
         ST_RX_EN: begin
            if (ftdi_rxf_n || rx_almost_full || (rx_beat && rx_last))
               state_next = ST_RX_WAIT;
         end
         ST_RX_WAIT: state_next = ST_RX_END;
         ST_RX_END:  state_next = ST_TURN;
         ST_TX_EN: begin
            if (ftdi_txe_n || !tx_tvalid || (tx_beat && (tx_tkeep != KEEP_ALL || tx_last)))
               state_next = ST_TURN;
         end
         ST_TURN: begin
            if (turn_done)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      oe_c      = 1'b1;
      rd_c      = 1'b1;
      wr_c      = 1'b1;
      moe_c     = 1'b0;
      data_c    = WORD_NONE;
      be_c      = KEEP_NONE;
      tx_tready = 1'b0;
      rx_tvalid = 1'b0;
      rx_tdata  = WORD_NONE;
      rx_tkeep  = KEEP_NONE;
      rx_tlast  = 1'b0;
      rx_active = 1'b0;
      tx_active = 1'b0;
      case (state)
         ST_RX_OE: begin
            oe_c      = 1'b0;
            rx_active = 1'b1;
         end
         ST_RX_EN: begin
            oe_c      = 1'b0;
            rd_c      = 1'b0;
            rx_active = 1'b1;
            rx_tvalid = ~ftdi_rxf_n;
            rx_tdata  = ftdi_data_in;
            rx_tkeep  = (CHIP_EW == 0) ? KEEP_ALL : ftdi_be_in;
         end
         ST_RX_WAIT: rx_active = 1'b1;
         ST_RX_END: begin
            rx_active = 1'b1;
            // Chip drained: close the packet with an empty marker beat.
            if (ftdi_rxf_n) begin
               rx_tvalid = 1'b1;
               rx_tlast  = 1'b1;
            end
         end
         ST_TX_EN: begin
            tx_active = 1'b1;
            moe_c     = 1'b1;
            tx_tready = ~ftdi_txe_n;
            wr_c      = ~(tx_tvalid & ~ftdi_txe_n);
            data_c    = tx_tdata;
            be_c      = tx_tkeep;
         end
         default: ;
      endcase
   end

   generate
      if (DRIVE_AT_NEGEDGE) begin : g_pins_neg
         always_ff @(negedge clk or negedge rstn) begin
            if (!rstn) begin
               ftdi_oe_n      <= 1'b1;
               ftdi_rd_n      <= 1'b1;
               ftdi_wr_n      <= 1'b1;
               ftdi_master_oe <= 1'b0;
               ftdi_data_out  <= WORD_NONE;
               ftdi_be_out    <= KEEP_NONE;
            end else begin
               ftdi_oe_n      <= oe_c;
               ftdi_rd_n      <= rd_c;
               ftdi_wr_n      <= wr_c;
               ftdi_master_oe <= moe_c;
               ftdi_data_out  <= data_c;
               ftdi_be_out    <= be_c;
            end
         end
      end else begin : g_pins_comb
         assign ftdi_oe_n      = oe_c;
         assign ftdi_rd_n      = rd_c;
         assign ftdi_wr_n      = wr_c;
         assign ftdi_master_oe = moe_c;
         assign ftdi_data_out  = data_c;
         assign ftdi_be_out    = be_c;
      end
   endgenerate

endmodule
